// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_CLR  = 3'd3,
        ST_DATA = 3'd4,
        ST_CHK  = 3'd5,
        ST_RUN  = 3'd6
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // States that belong to an in-flight frame.
    function automatic logic is_frame_state(input loader_state_t s);
        logic r_hit;
        case (s)
            ST_HDR0, ST_HDR1, ST_CLR, ST_DATA, ST_CHK: r_hit = 1'b1;
            default:                                   r_hit = 1'b0;
        endcase
        return r_hit;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] imem_write_instr;
    logic        imem_write_en;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_write_instr,
        output imem_write_en
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_write_instr,
        input  imem_write_en
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: assembles 32-bit words, writes them to
// instruction memory and starts the core once the frame checksum verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    imem_loader_if.master                  bus,
    output logic                           cpu_reset,
    output logic                           cpu_start,
    output logic                           busy,
    output logic [1:0]                     err,
    output logic [$clog2(MAX_WORDS+1)-1:0] words_loaded
);

    localparam int WL_W  = $clog2(MAX_WORDS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]      MAX_LEN  = 17'(MAX_WORDS);

    loader_state_t    r_state;
    loader_state_t    w_state_nxt;

    logic             r_rx_ready;
    logic             r_write_en;
    logic [31:0]      r_write_instr;
    logic             r_cpu_reset;
    logic             r_cpu_start;
    logic             r_busy;
    logic [1:0]       r_err;
    logic [WL_W-1:0]  r_words_loaded;

    logic [7:0]       r_len_lo;
    logic [WL_W-1:0]  r_len;
    logic [1:0]       r_byte_idx;
    logic [23:0]      r_asm;
    logic [7:0]       r_chk;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic             w_accept;
    logic             w_is_sync;
    logic [15:0]      w_len_full;
    logic             w_len_bad;
    logic             w_word_done;
    logic [WL_W-1:0]  w_words_inc;
    logic             w_last_word;
    logic             w_counting;
    logic             w_timeout;

    logic             w_rx_ready_nxt;
    logic             w_write_en_nxt;
    logic             w_cpu_reset_nxt;
    logic             w_cpu_start_nxt;
    logic             w_busy_nxt;
    logic [1:0]       w_err_nxt;

    assign w_accept    = bus.rx_valid & r_rx_ready;
    assign w_is_sync   = (bus.rx_data == SYNC_BYTE);
    assign w_len_full  = {bus.rx_data, r_len_lo};
    assign w_len_bad   = (w_len_full == 16'd0) || ({1'b0, w_len_full} > MAX_LEN);
    assign w_word_done = (r_state == ST_DATA) && w_accept && (r_byte_idx == 2'd3);
    assign w_words_inc = r_words_loaded + WL_W'(1);
    assign w_last_word = (w_words_inc == r_len);
    assign w_counting  = (r_state == ST_HDR0) || (r_state == ST_HDR1) ||
                         (r_state == ST_DATA) || (r_state == ST_CHK);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_timeout   = w_counting && !w_accept && (r_tmo_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_sync) w_state_nxt = ST_HDR0;
                else                       w_state_nxt = ST_IDLE;
            end
            ST_HDR0: begin
                if (w_timeout)     w_state_nxt = ST_IDLE;
                else if (w_accept) w_state_nxt = ST_HDR1;
                else               w_state_nxt = ST_HDR0;
            end
            ST_HDR1: begin
                if (w_timeout)     w_state_nxt = ST_IDLE;
                else if (w_accept) w_state_nxt = w_len_bad ? ST_IDLE : ST_CLR;
                else               w_state_nxt = ST_HDR1;
            end
            ST_CLR:  w_state_nxt = ST_DATA;
            ST_DATA: begin
                if (w_timeout)                      w_state_nxt = ST_IDLE;
                else if (w_word_done && w_last_word) w_state_nxt = ST_CHK;
                else                                w_state_nxt = ST_DATA;
            end
            ST_CHK: begin
                if (w_timeout)     w_state_nxt = ST_IDLE;
                else if (w_accept) w_state_nxt = (bus.rx_data == r_chk) ? ST_RUN : ST_IDLE;
                else               w_state_nxt = ST_CHK;
            end
            ST_RUN: begin
                if (w_accept && w_is_sync) w_state_nxt = ST_HDR0;
                else                       w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; values are registered so they track the entered state.
    always_comb begin
        w_rx_ready_nxt  = (w_state_nxt != ST_CLR);
        w_busy_nxt      = is_frame_state(w_state_nxt);
        w_cpu_start_nxt = (w_state_nxt == ST_RUN);
        w_write_en_nxt  = w_word_done;
        w_cpu_reset_nxt = r_cpu_reset;
        case (w_state_nxt)
            ST_IDLE, ST_CLR: w_cpu_reset_nxt = 1'b1;
            ST_RUN:          w_cpu_reset_nxt = 1'b0;
            default:         w_cpu_reset_nxt = r_cpu_reset;
        endcase
        w_err_nxt = r_err;
        if (w_timeout) begin
            w_err_nxt = ERR_TIMEOUT;
        end else if (w_accept && w_is_sync && ((r_state == ST_IDLE) || (r_state == ST_RUN))) begin
            w_err_nxt = ERR_NONE;
        end else if (w_accept && (r_state == ST_HDR1) && w_len_bad) begin
            w_err_nxt = ERR_LEN;
        end else if (w_accept && (r_state == ST_CHK) && (bus.rx_data != r_chk)) begin
            w_err_nxt = ERR_CHK;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_ready    <= 1'b1;
            r_write_en    <= 1'b0;
            r_write_instr <= 32'd0;
            r_cpu_reset   <= 1'b1;
            r_cpu_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= ERR_NONE;
        end else begin
            r_rx_ready  <= w_rx_ready_nxt;
            r_write_en  <= w_write_en_nxt;
            r_cpu_reset <= w_cpu_reset_nxt;
            r_cpu_start <= w_cpu_start_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
            if (w_word_done) r_write_instr <= {bus.rx_data, r_asm};
            else             r_write_instr <= r_write_instr;
        end
    end

    // Header latch, little-endian word assembly, checksum and word count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len_lo       <= 8'd0;
            r_len          <= '0;
            r_byte_idx     <= 2'd0;
            r_asm          <= 24'd0;
            r_chk          <= 8'd0;
            r_words_loaded <= '0;
        end else begin
            case (r_state)
                ST_HDR0: if (w_accept) r_len_lo <= bus.rx_data;
                ST_HDR1: if (w_accept) r_len <= WL_W'(w_len_full);
                ST_CLR: begin
                    r_byte_idx     <= 2'd0;
                    r_asm          <= 24'd0;
                    r_chk          <= 8'd0;
                    r_words_loaded <= '0;
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_asm      <= {bus.rx_data, r_asm[23:8]};
                        r_chk      <= r_chk ^ bus.rx_data;
                    end
                    if (w_word_done) r_words_loaded <= w_words_inc;
                end
                default: r_len_lo <= r_len_lo;
            endcase
        end
    end

    // Inter-byte idle counter, live only while a frame is being received.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
        end else if (!w_counting || w_accept || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign bus.rx_ready         = r_rx_ready;
    assign bus.imem_write_en    = r_write_en;
    assign bus.imem_write_instr = r_write_instr;
    assign cpu_reset            = r_cpu_reset;
    assign cpu_start            = r_cpu_start;
    assign busy                 = r_busy;
    assign err                  = r_err;
    assign words_loaded         = r_words_loaded;

endmodule
